// File: rtl/fg_burst_dds_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fg_burst_dds_gen: burst-capable DDS waveform generator, two-stage output  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fg_burst_dds_gen #(
    parameter int BITWIDTH           = 8,
    parameter int BITWIDTH_PRESCALAR = 9,
    parameter int BITWIDTH_PHASE     = 16,
    parameter int BITWIDTH_BURST     = 8
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          enable_i,
    input  logic                          trigger_i,
    input  logic                          cfg_valid_i,
    output logic                          cfg_ready_o,
    input  logic [1:0]                    mode_i,
    input  logic                          radix_i,
    input  logic [BITWIDTH_PRESCALAR-1:0] prescaler_i,
    input  logic [BITWIDTH_PHASE-1:0]     phase_inc_i,
    input  logic [BITWIDTH-1:0]           duty_i,
    input  logic [BITWIDTH-1:0]           amplitude_i,
    input  logic [BITWIDTH-1:0]           offset_i,
    input  logic [BITWIDTH_BURST-1:0]     burst_i,
    output logic [BITWIDTH-1:0]           out_o,
    output logic                          outValid_STRB_o,
    output logic                          busy_o,
    output logic                          period_strb_o
);

    localparam logic [BITWIDTH-1:0] HALF    = {1'b1, {(BITWIDTH-1){1'b0}}};
    localparam logic [BITWIDTH-1:0] HALF_M1 = {1'b0, {(BITWIDTH-1){1'b1}}};

    typedef struct packed {
        logic [1:0]                    mode;
        logic                          radix;
        logic [BITWIDTH_PRESCALAR-1:0] prescaler;
        logic [BITWIDTH_PHASE-1:0]     phase_inc;
        logic [BITWIDTH-1:0]           duty;
        logic [BITWIDTH-1:0]           amplitude;
        logic [BITWIDTH-1:0]           offset;
        logic [BITWIDTH_BURST-1:0]     burst;
    } cfg_t;

    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t                          state;
    cfg_t                            in_cfg, shadow_cfg, active_cfg;
    logic                            pending;
    logic [BITWIDTH_PRESCALAR-1:0]   presc_cnt;
    logic [BITWIDTH_PHASE-1:0]       phase, phase_sum;
    logic [BITWIDTH_BURST-1:0]       wrap_cnt, wrap_next;
    logic                            tick, carry, last_wrap, xfer;

    assign in_cfg      = {mode_i, radix_i, prescaler_i, phase_inc_i, duty_i,
                          amplitude_i, offset_i, burst_i};
    assign cfg_ready_o = !pending;
    assign busy_o      = (state == RUN);
    assign xfer        = cfg_valid_i && !pending;
    assign tick        = (state == RUN) && enable_i && (presc_cnt == active_cfg.prescaler);
    assign {carry, phase_sum} = {1'b0, phase} + {1'b0, active_cfg.phase_inc};
    assign wrap_next   = wrap_cnt + BITWIDTH_BURST'(1);
    assign last_wrap   = (active_cfg.burst != '0) && (wrap_next == active_cfg.burst);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state         <= IDLE;
            presc_cnt     <= '0;
            phase         <= '0;
            wrap_cnt      <= '0;
            period_strb_o <= 1'b0;
        end else begin
            period_strb_o <= tick && carry;
            case (state)
                IDLE: begin
                    presc_cnt <= '0;
                    phase     <= '0;
                    wrap_cnt  <= '0;
                    if (enable_i && ((active_cfg.burst == '0) || trigger_i)) state <= RUN;
                end
                RUN: begin
                    if (!enable_i) begin
                        state     <= IDLE;
                        presc_cnt <= '0;
                        phase     <= '0;
                        wrap_cnt  <= '0;
                    end else if (tick) begin
                        presc_cnt <= '0;
                        phase     <= phase_sum;
                        if (carry) begin
                            wrap_cnt <= wrap_next;
                            // final wrap keeps its phase so the last sample still reaches the pipeline
                            if (last_wrap) state <= IDLE;
                        end
                    end else begin
                        presc_cnt <= presc_cnt + BITWIDTH_PRESCALAR'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            shadow_cfg <= '0;
            active_cfg <= '0;
            pending    <= 1'b0;
        end else if (xfer) begin
            shadow_cfg <= in_cfg;
            pending    <= 1'b1;
        end else if (pending && ((state == IDLE) || (tick && carry))) begin
            active_cfg <= shadow_cfg;
            pending    <= 1'b0;
        end
    end

    logic                  s0_valid, s0_radix, s1_valid, s1_radix;
    logic [1:0]            s0_mode;
    logic [BITWIDTH-1:0]   s0_duty, s0_amp, s0_off, s1_amp, s1_off, s1_wave;
    logic [BITWIDTH-1:0]   u, wave_c, scaled, sat_c;
    logic [BITWIDTH-2:0]   fold;
    logic signed [2*BITWIDTH:0] mul_a, mul_b, prod;
    logic [BITWIDTH:0]     sum_c;

    assign u    = phase[BITWIDTH_PHASE-1 -: BITWIDTH];
    assign fold = u[BITWIDTH-1] ? ~u[BITWIDTH-2:0] : u[BITWIDTH-2:0];

    always_comb begin
        wave_c = HALF_M1;
        case (s0_mode)
            2'b00:   wave_c = u - HALF;
            2'b01:   wave_c = (u < s0_duty) ? HALF_M1 : HALF;
            2'b10:   wave_c = {fold, 1'b0} - HALF;
            default: wave_c = HALF_M1;
        endcase
    end

    // floor(w*amp / 2^BITWIDTH) always fits in BITWIDTH signed bits
    assign mul_a  = {{(BITWIDTH+1){s1_wave[BITWIDTH-1]}}, s1_wave};
    assign mul_b  = {{(BITWIDTH+1){1'b0}}, s1_amp};
    assign prod   = mul_a * mul_b;
    assign scaled = prod[2*BITWIDTH-1:BITWIDTH];
    assign sum_c  = {scaled[BITWIDTH-1], scaled} + {s1_off[BITWIDTH-1], s1_off};

    always_comb begin
        sat_c = sum_c[BITWIDTH-1:0];
        if (sum_c[BITWIDTH] != sum_c[BITWIDTH-1]) sat_c = sum_c[BITWIDTH] ? HALF : HALF_M1;
    end

    logic unused_bits;
    assign unused_bits = ^{prod[2*BITWIDTH], prod[BITWIDTH-1:0], phase[BITWIDTH_PHASE-BITWIDTH-1:0]};

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            s0_valid        <= 1'b0;
            s0_mode         <= '0;
            s0_radix        <= 1'b0;
            s0_duty         <= '0;
            s0_amp          <= '0;
            s0_off          <= '0;
            s1_valid        <= 1'b0;
            s1_radix        <= 1'b0;
            s1_amp          <= '0;
            s1_off          <= '0;
            s1_wave         <= '0;
            out_o           <= '0;
            outValid_STRB_o <= 1'b0;
        end else begin
            s0_valid <= tick;
            if (tick) begin
                s0_mode  <= active_cfg.mode;
                s0_radix <= active_cfg.radix;
                s0_duty  <= active_cfg.duty;
                s0_amp   <= active_cfg.amplitude;
                s0_off   <= active_cfg.offset;
            end
            s1_valid <= s0_valid;
            if (s0_valid) begin
                s1_wave  <= wave_c;
                s1_radix <= s0_radix;
                s1_amp   <= s0_amp;
                s1_off   <= s0_off;
            end
            outValid_STRB_o <= s1_valid;
            if (s1_valid) out_o <= s1_radix ? (sat_c ^ HALF) : sat_c;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fg_burst_dds_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fg_burst_dds_gen: randomized bench against a sample-level model        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fg_burst_dds_gen;

    logic       clk_i = 1'b0;
    logic       rstn_i, enable_i, trigger_i, cfg_valid_i, cfg_ready_o;
    logic [1:0] mode_i;
    logic       radix_i;
    logic [8:0] prescaler_i;
    logic [15:0] phase_inc_i;
    logic [7:0] duty_i, amplitude_i, offset_i, burst_i, out_o;
    logic       outValid_STRB_o, busy_o, period_strb_o;

    always #5 clk_i = ~clk_i;

    fg_burst_dds_gen dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .enable_i(enable_i), .trigger_i(trigger_i),
        .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o), .mode_i(mode_i),
        .radix_i(radix_i), .prescaler_i(prescaler_i), .phase_inc_i(phase_inc_i),
        .duty_i(duty_i), .amplitude_i(amplitude_i), .offset_i(offset_i),
        .burst_i(burst_i), .out_o(out_o), .outValid_STRB_o(outValid_STRB_o),
        .busy_o(busy_o), .period_strb_o(period_strb_o)
    );

    typedef struct {
        int mode, radix, presc, inc, duty, amp, off, burst;
    } mcfg_t;

    mcfg_t act, sh;
    int    m_run, m_phase, m_presc, m_wraps, m_pending, m_last_out;
    int    e_valid [4096];
    int    e_out   [4096];
    int    e_pstrb [4096];
    int    cyc, total, bad;
    logic  run_en;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Expected sample straight from the waveform/scaling rules, as an 8-bit pattern
    function automatic int ref_sample(input int ph, input mcfg_t c);
        int u, w, t, y, s, off;
        u = ph >> 8;
        case (c.mode)
            0: w = u - 128;
            1: w = (u < c.duty) ? 127 : -128;
            2: begin
                t = (u >= 128) ? (255 - u) : u;
                w = 2 * t - 128;
            end
            default: w = 127;
        endcase
        y   = (w * c.amp) >>> 8;
        off = (c.off >= 128) ? c.off - 256 : c.off;
        s   = y + off;
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        if (c.radix != 0) s = s + 128;
        return s & 255;
    endfunction

    function automatic void model_reset();
        act = '{0, 0, 0, 0, 0, 0, 0, 0};
        sh  = act;
        m_run = 0; m_phase = 0; m_presc = 0; m_wraps = 0; m_pending = 0; m_last_out = 0;
        for (int i = 0; i < 4096; i++) begin
            e_valid[i] = 0; e_out[i] = 0; e_pstrb[i] = 0;
        end
    endfunction

    // Advance the model across the coming rising edge using the inputs now driven
    function automatic void model_step();
        int    nphase;
        bit    tick, wrap, xfer, was_run;
        mcfg_t incfg;
        incfg   = '{int'(mode_i), int'(radix_i), int'(prescaler_i), int'(phase_inc_i),
                    int'(duty_i), int'(amplitude_i), int'(offset_i), int'(burst_i)};
        was_run = (m_run != 0);
        xfer    = cfg_valid_i && (m_pending == 0);
        tick    = was_run && enable_i && (m_presc == act.presc);
        wrap    = 1'b0;
        nphase  = m_phase;
        if (tick) begin
            nphase = m_phase + act.inc;
            wrap   = (nphase > 65535);
            nphase = nphase & 65535;
            e_valid[(cyc + 3) % 4096] = 1;
            e_out[(cyc + 3) % 4096]   = ref_sample(nphase, act);
            if (wrap) e_pstrb[(cyc + 1) % 4096] = 1;
        end
        if (!was_run) begin
            m_phase = 0; m_presc = 0; m_wraps = 0;
            if (enable_i && (act.burst == 0 || trigger_i)) m_run = 1;
        end else if (!enable_i) begin
            m_run = 0; m_phase = 0; m_presc = 0; m_wraps = 0;
        end else if (tick) begin
            m_presc = 0;
            m_phase = nphase;
            if (wrap) begin
                m_wraps++;
                if (act.burst != 0 && (m_wraps % 256) == act.burst) m_run = 0;
            end
        end else begin
            m_presc++;
        end
        if (xfer) begin
            sh = incfg;
            m_pending = 1;
        end else if (m_pending != 0 && (!was_run || wrap)) begin
            act = sh;
            m_pending = 0;
        end
    endfunction

    task automatic check_cycle();
        int idx;
        idx = cyc % 4096;
        if (e_valid[idx] != 0) m_last_out = e_out[idx];
        chk_eq("strobe", outValid_STRB_o, e_valid[idx]);
        chk_eq("out", out_o, m_last_out);
        chk_eq("period", period_strb_o, e_pstrb[idx]);
        chk_eq("busy", busy_o, m_run);
        chk_eq("ready", cfg_ready_o, (m_pending == 0));
        e_valid[idx] = 0;
        e_pstrb[idx] = 0;
    endtask

    task automatic do_cycle(input logic en, input logic trig, input logic cv);
        enable_i = en; trigger_i = trig; cfg_valid_i = cv;
        model_step();
        @(posedge clk_i);
        @(negedge clk_i);
        cyc++;
        check_cycle();
    endtask

    task automatic set_cfg(input int mode, input int radix, input int presc, input int inc,
                           input int duty, input int amp, input int off, input int burst);
        mode_i = mode[1:0]; radix_i = radix[0]; prescaler_i = presc[8:0];
        phase_inc_i = inc[15:0]; duty_i = duty[7:0]; amplitude_i = amp[7:0];
        offset_i = off[7:0]; burst_i = burst[7:0];
    endtask

    task automatic rand_cfg();
        set_cfg($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                $urandom_range(16'h0C00, 16'h7FFF), $urandom_range(0, 255),
                $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 4));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk_eq({tag, "_out"}, out_o, 0);
        chk_eq({tag, "_strobe"}, outValid_STRB_o, 0);
        chk_eq({tag, "_period"}, period_strb_o, 0);
        chk_eq({tag, "_busy"}, busy_o, 0);
        chk_eq({tag, "_ready"}, cfg_ready_o, 1);
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0;
        rstn_i = 1'b1; enable_i = 1'b0; trigger_i = 1'b0; cfg_valid_i = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #2 rstn_i = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (2) @(negedge clk_i);
        rstn_i = 1'b1;

        // saw, continuous, one tick per clock
        set_cfg(0, 0, 0, 16'h1000, 0, 255, 0, 0);
        do_cycle(0, 0, 1);
        repeat (40) do_cycle(1, 0, 0);
        repeat (4) do_cycle(0, 0, 0);

        // square with saturating offset, signed then unsigned
        set_cfg(1, 0, 0, 16'h1000, 8'h80, 255, 100, 0);
        do_cycle(0, 0, 1);
        repeat (24) do_cycle(1, 0, 0);
        do_cycle(0, 0, 0);
        set_cfg(1, 1, 0, 16'h1000, 8'h80, 255, 100, 0);
        do_cycle(0, 0, 1);
        repeat (24) do_cycle(1, 0, 0);
        repeat (3) do_cycle(0, 0, 0);

        // burst of 3 wraps, extra trigger while running
        set_cfg(2, 0, 0, 16'h4000, 8'h40, 200, 251, 3);
        do_cycle(0, 0, 1);
        do_cycle(0, 0, 0);
        repeat (3) do_cycle(1, 0, 0);
        do_cycle(1, 1, 0);
        repeat (4) do_cycle(1, 0, 0);
        do_cycle(1, 1, 0);
        repeat (12) do_cycle(1, 0, 0);
        do_cycle(1, 1, 0);
        repeat (16) do_cycle(1, 0, 0);
        repeat (3) do_cycle(0, 0, 0);

        // prescaler 2, mid-run config change, back-to-back valid stalls
        set_cfg(0, 0, 2, 16'h2000, 0, 255, 0, 0);
        do_cycle(0, 0, 1);
        repeat (10) do_cycle(1, 0, 0);
        set_cfg(0, 0, 2, 16'h3000, 0, 255, 0, 0);
        do_cycle(1, 0, 1);
        set_cfg(3, 1, 2, 16'h0800, 0, 128, 5, 0);
        repeat (30) do_cycle(1, 0, 1);
        repeat (40) do_cycle(1, 0, 0);
        repeat (5) do_cycle(0, 0, 0);

        run_en = 1'b0;
        repeat (3000) begin
            rand_cfg();
            if ($urandom_range(0, 99) < 3) run_en = ~run_en;
            if ($urandom_range(0, 99) < 20) run_en = 1'b1;
            do_cycle(run_en, ($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 6));
        end

        // asynchronous reset in the middle of a burst with a pending config
        set_cfg(0, 0, 1, 16'h2000, 0, 255, 0, 5);
        do_cycle(0, 0, 1);
        do_cycle(1, 1, 0);
        repeat (6) do_cycle(1, 0, 0);
        rand_cfg();
        do_cycle(1, 0, 1);
        #2 rstn_i = 1'b0;
        #1 check_reset_outputs("async_reset");
        model_reset();
        cfg_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rstn_i = 1'b1;

        repeat (300) begin
            rand_cfg();
            if ($urandom_range(0, 99) < 3) run_en = ~run_en;
            do_cycle(run_en, ($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 6));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
